imem_loader: RTL and testbench

//  Writer side of the instruction-memory interface that the pipelined core reads during fetch.
//  - Accepts a byte stream over a valid/ready handshake.
//  - Assembles 19-bit instruction words from the stream and writes them to instruction memory from address 0.
//  - Holds the core in reset until the whole image has loaded.
//  - Sits between the host byte link and the core/imem at the top level.

---
 rtl/imem_loader_pkg.sv | 24 ++
 rtl/imem_loader_if.sv | 22 ++
 rtl/imem_loader.sv | 185 ++++++++++++++++++
 tb/tb_imem_loader.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Optional feature macro: IMEM_LOADER_CSUM_EN.
package imem_loader_pkg;

  localparam int INSTR_W = 19;
  localparam int BYTE_W  = 8;
  localparam int LEN_W   = 16;

  // B0 carries only the top instruction bits; the rest must be zero
  localparam int B0_BITS = INSTR_W - 2 * BYTE_W;

  typedef enum logic [3:0] {
    LEN_HI,
    LEN_LO,
    B0,
    B1,
    B2,
    WRITE,
    CSUM,
    DONE,
    ERR
  } ld_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Valid/ready byte-stream link from the host into the loader.
// Optional feature macro: none.
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte image into imem and holds the core in reset.
// Optional feature macro: IMEM_LOADER_CSUM_EN (trailing XOR checksum byte).
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_req,
  imem_loader_if.slave       in_if,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_reset,
  output logic               done,
  output logic               error
);

  ld_state_e          state_q;
  logic               rdy_q;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [INSTR_W-1:0] wdata_q;
  logic               cpu_rst_q;
  logic               done_q;
  logic               err_q;
  logic [LEN_W-1:0]   len_q;
  logic [ADDR_W:0]    idx_q;
  logic [LEN_W-1:0]   asm_q;

  logic               fire;
  logic [BYTE_W-1:0]  din;
  logic [LEN_W-1:0]   len_d;
  logic               restart;

  assign din     = in_if.in_data;
  assign fire    = in_if.in_valid & rdy_q;
  assign len_d   = {len_q[LEN_W-1:BYTE_W], din};
  assign restart = load_req &
                   ((state_q == DONE) | (state_q == ERR));

  assign in_if.in_ready = rdy_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_reset  = cpu_rst_q;
  assign done       = done_q;
  assign error      = err_q;

`ifdef IMEM_LOADER_CSUM_EN
  logic [BYTE_W-1:0] csum_q;

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      csum_q <= '0;
    end else if (fire && state_q != CSUM) begin
      csum_q <= csum_q ^ din;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= LEN_HI;
      rdy_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      len_q     <= '0;
      idx_q     <= '0;
      asm_q     <= '0;
    end else begin
      we_q <= 1'b0;
      unique case (state_q)
        LEN_HI: begin
          rdy_q <= 1'b1;
          if (fire) begin
            len_q[LEN_W-1:BYTE_W] <= din;
            state_q <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (fire) begin
            len_q <= len_d;
            if (len_d > LEN_W'(DEPTH)) begin
              state_q <= ERR;
              rdy_q   <= 1'b0;
              err_q   <= 1'b1;
            end else if (len_d == '0) begin
`ifdef IMEM_LOADER_CSUM_EN
              state_q <= CSUM;
`else
              state_q   <= DONE;
              rdy_q     <= 1'b0;
              done_q    <= 1'b1;
              cpu_rst_q <= 1'b0;
`endif
            end else begin
              state_q <= B0;
            end
          end
        end
        B0: begin
          if (fire) begin
            if (|din[BYTE_W-1:B0_BITS]) begin
              state_q <= ERR;
              rdy_q   <= 1'b0;
              err_q   <= 1'b1;
            end else begin
              asm_q   <= {asm_q[BYTE_W-1:0], din};
              state_q <= B1;
            end
          end
        end
        B1: begin
          if (fire) begin
            asm_q   <= {asm_q[BYTE_W-1:0], din};
            state_q <= B2;
          end
        end
        B2: begin
          if (fire) begin
            wdata_q <= INSTR_W'({asm_q, din});
            addr_q  <= idx_q[ADDR_W-1:0];
            idx_q   <= idx_q + 1'b1;
            we_q    <= 1'b1;
            rdy_q   <= 1'b0;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          if (LEN_W'(idx_q) == len_q) begin
`ifdef IMEM_LOADER_CSUM_EN
            state_q <= CSUM;
            rdy_q   <= 1'b1;
`else
            state_q   <= DONE;
            done_q    <= 1'b1;
            cpu_rst_q <= 1'b0;
`endif
          end else begin
            state_q <= B0;
            rdy_q   <= 1'b1;
          end
        end
`ifdef IMEM_LOADER_CSUM_EN
        CSUM: begin
          if (fire) begin
            rdy_q <= 1'b0;
            if (din == csum_q) begin
              state_q   <= DONE;
              done_q    <= 1'b1;
              cpu_rst_q <= 1'b0;
            end else begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end
          end
        end
`endif
        DONE, ERR: begin
          if (load_req) begin
            state_q   <= LEN_HI;
            rdy_q     <= 1'b1;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            idx_q     <= '0;
          end
        end
        default: begin
          state_q <= ERR;
          rdy_q   <= 1'b0;
          err_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: queued expected writes vs observed.
// Optional feature macro: IMEM_LOADER_CSUM_EN.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int ADDR_W = 8;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               load_req = 1'b0;
  logic               imem_we;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_wdata;
  logic               cpu_reset;
  logic               done;
  logic               error;

  imem_loader_if bif ();

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(256)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_req   (load_req),
    .in_if      (bif.slave),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int we_cnt = 0;
  logic prev_we = 1'b0;

  logic [ADDR_W-1:0]  exp_addr[$];
  logic [INSTR_W-1:0] exp_data[$];

  logic [INSTR_W-1:0] img[2] = '{19'h12345, 19'h6789A};

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (imem_we) begin
      we_cnt++;
      chk("we_b2b", 32'(prev_we), 0);
      if (exp_addr.size() == 0) begin
        chk("unexp_we", 1, 0);
      end else begin
        chk("waddr", 32'(imem_addr), 32'(exp_addr.pop_front()));
        chk("wdata", 32'(imem_wdata), 32'(exp_data.pop_front()));
      end
    end
    prev_we = imem_we;
  end

  task automatic send(input logic [7:0] b, input bit tog);
    int t = 0;
    bif.in_valid = 1'b1;
    bif.in_data  = b;
    while (!bif.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bif.in_ready) begin
      chk("send_timeout", 0, 1);
      bif.in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bif.in_valid = 1'b0;
    if (tog) @(negedge clk);
  endtask

  task automatic run_frame(input bit tog, input bit bad);
    logic [7:0] x = 8'h00;
    logic [7:0] b;
    send(8'h00, tog);
    send(8'h02, tog);
    x = 8'h02;
    for (int i = 0; i < 2; i++) begin
      b = {5'b0, img[i][18:16]};
      send(b, tog);
      x ^= b;
      b = img[i][15:8];
      send(b, tog);
      x ^= b;
      b = img[i][7:0];
      exp_addr.push_back(ADDR_W'(i));
      exp_data.push_back(img[i]);
      send(b, tog);
      x ^= b;
    end
`ifdef IMEM_LOADER_CSUM_EN
    send(bad ? 8'hFF : x, tog);
`else
    if (bad) chk("bad_csum_needs_macro", 0, 0);
`endif
  endtask

  task automatic wait_end();
    int t = 0;
    while (!(done | error) && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("end_timeout", 32'(done | error), 1);
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rdy"}, 32'(bif.in_ready), 0);
    chk({tag, "_we"}, 32'(imem_we), 0);
    chk({tag, "_addr"}, 32'(imem_addr), 0);
    chk({tag, "_wdata"}, 32'(imem_wdata), 0);
    chk({tag, "_cpurst"}, 32'(cpu_reset), 1);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(error), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bif.in_valid = 1'b0;
    bif.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rdy_post_rst", 32'(bif.in_ready), 1);

    // nominal two-word image
    base = we_cnt;
    run_frame(1'b0, 1'b0);
    wait_end();
    chk("t1_done", 32'(done), 1);
    chk("t1_cpurst", 32'(cpu_reset), 0);
    chk("t1_err", 32'(error), 0);
    chk("t1_wecnt", 32'(we_cnt - base), 2);
    chk("t1_q_empty", 32'(exp_addr.size()), 0);
    bif.in_valid = 1'b1;
    bif.in_data  = 8'h55;
    repeat (3) @(negedge clk);
    chk("t1_extra_rdy", 32'(bif.in_ready), 0);
    chk("t1_extra_done", 32'(done), 1);
    bif.in_valid = 1'b0;
    pulse_load();
    chk("ld_done", 32'(done), 0);
    chk("ld_cpurst", 32'(cpu_reset), 1);
    chk("ld_rdy", 32'(bif.in_ready), 1);

    // same frame with gaps in in_valid
    base = we_cnt;
    run_frame(1'b1, 1'b0);
    wait_end();
    chk("t2_done", 32'(done), 1);
    chk("t2_wecnt", 32'(we_cnt - base), 2);
    pulse_load();

    // empty image
    base = we_cnt;
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
`ifdef IMEM_LOADER_CSUM_EN
    send(8'h00, 1'b0);
`endif
    chk("t3_done", 32'(done), 1);
    chk("t3_cpurst", 32'(cpu_reset), 0);
    chk("t3_wecnt", 32'(we_cnt - base), 0);
    pulse_load();

    // length beyond depth
    base = we_cnt;
    send(8'h01, 1'b0);
    send(8'h01, 1'b0);
    repeat (2) @(negedge clk);
    chk("t4_err", 32'(error), 1);
    chk("t4_cpurst", 32'(cpu_reset), 1);
    chk("t4_rdy", 32'(bif.in_ready), 0);
    chk("t4_wecnt", 32'(we_cnt - base), 0);
    pulse_load();
    chk("t4_ld_err", 32'(error), 0);

    // bad B0 upper bits
    base = we_cnt;
    send(8'h00, 1'b0);
    send(8'h01, 1'b0);
    send(8'h08, 1'b0);
    chk("t5_err", 32'(error), 1);
    chk("t5_rdy", 32'(bif.in_ready), 0);
    chk("t5_wecnt", 32'(we_cnt - base), 0);
    pulse_load();
    chk("t5_ld_err", 32'(error), 0);
    chk("t5_ld_rdy", 32'(bif.in_ready), 1);
    run_frame(1'b0, 1'b0);
    wait_end();
    chk("t5_reload_done", 32'(done), 1);
    pulse_load();

`ifdef IMEM_LOADER_CSUM_EN
    base = we_cnt;
    run_frame(1'b0, 1'b1);
    wait_end();
    chk("t6_err", 32'(error), 1);
    chk("t6_cpurst", 32'(cpu_reset), 1);
    chk("t6_wecnt", 32'(we_cnt - base), 2);
    pulse_load();
`endif

    // reset in the middle of a word
    send(8'h00, 1'b0);
    send(8'h02, 1'b0);
    send(8'h01, 1'b0);
    send(8'h23, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("mid");
    reset = 1'b0;
    run_frame(1'b0, 1'b0);
    wait_end();
    chk("post_rst_done", 32'(done), 1);
    chk("final_q_empty", 32'(exp_addr.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
